uart_wb_host: RTL and testbench
===============================

Name: uart_wb_host

Overview:
- Host-side endpoint of the UART memory-access protocol. It sits in the FPGA loader and bench harness and drives the UART-to-Wishbone bridge inside the SoC.
- Converts parallel read/write requests into command frames on o_uart_tx.
- For reads, collects the 4-byte reply on i_uart_rx and returns it on a valid/ready response port.
- Contains its own 8N1 UART transmitter and receiver, plus a reply timeout.

Parameters:
- DATA_WIDTH, 32, data word width; fixed at 32 (4 bytes per word).
- ADDR_WIDTH, 32, address width; fixed at 32 (4 bytes per address).
- BAUD_RATE, 9600, UART bit rate.
- CLOCK_FREQ, 50000000, clk frequency in Hz. CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division, must be ≥4).
- CMD_READ, 8'h01, opcode byte for a read.
- CMD_WRITE, 8'hAA, opcode byte for a write.
- TIMEOUT_CYCLES, 2000000, maximum clk cycles to wait for each reply byte.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- i_req_valid  input  1  request present
- o_req_ready  output  1  request accepted when valid & ready
- i_req_we  input  1  1 = write, 0 = read
- i_req_addr  input  32  target address
- i_req_data  input  32  write data (ignored for reads)
- o_rsp_valid  output  1  response present
- i_rsp_ready  input  1  response consumed when valid & ready
- o_rsp_data  output  32  read data (0 for writes and errors)
- o_rsp_err  output  1  reply timeout or framing error
- o_uart_tx  output  1  serial line to the bridge; idles high
- i_uart_rx  input  1  serial line from the bridge; asynchronous

Behaviour:
- Reset: one clock; rst is synchronous and active-high. All outputs take their reset values in the cycle after rst is sampled high, including mid-frame:
  - o_uart_tx=1 (frame truncated), o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0.
  - FSM goes to IDLE; all counters and RX state clear.
  - o_req_ready rises the first cycle after rst deasserts.
- Framing:
  - Write = 9 bytes: CMD_WRITE, addr[31:24], addr[23:16], addr[15:8], addr[7:0], data[31:24] … data[7:0].
  - Read = 5 bytes: CMD_READ, addr MSB-first.
  - Read reply = 4 bytes, data MSB-first.
  - Each byte is sent 8N1: start 0, bits LSB-first, stop 1. Each bit lasts exactly CLKS_PER_BIT cycles.
  - Consecutive bytes are back-to-back: a start bit follows the previous stop bit immediately, with no idle gap.
- FSM states: IDLE, SEND, WAIT_RX, RESP.
  - IDLE: o_req_ready=1. On valid&ready, latch we/addr/data, set byte index=0, go to SEND. The start bit is driven the next cycle.
  - SEND: shift out bytes 0..8 (write) or 0..4 (read). After the last stop bit completes:
    - write → RESP with data=0, err=0;
    - read → WAIT_RX with reply count=0 and timeout counter=0.
  - WAIT_RX: each good received byte is shifted into o_rsp_data MSB-first and resets the timeout counter.
    - Fourth good byte → RESP with err=0.
    - Timeout counter reaching TIMEOUT_CYCLES → RESP with data=0, err=1.
    - Stop bit sampled 0 → RESP with data=0, err=1. Any partial data is discarded.
  - RESP: o_rsp_valid=1; o_rsp_data and o_rsp_err held stable until i_rsp_ready. On valid&ready go to IDLE; o_req_ready=1 the following cycle.
  - o_req_ready=0 in every state except IDLE.
- RX path:
  - i_uart_rx passes through a 2-flop synchronizer.
  - A start bit is detected on the synchronized 1→0 edge and sampled at CLKS_PER_BIT/2. If it is high at that point, treat it as a glitch and return to RX idle.
  - Data bits are sampled mid-bit; the stop bit is checked mid-bit.
  - The receiver runs in all states. Bytes completing outside WAIT_RX are discarded and have no effect on err.
- Simultaneous events:
  - Fourth byte completes in the same cycle as timeout expiry → the byte wins (err=0).
  - i_req_valid while not in IDLE → ignored; the request stays pending.
  - i_rsp_ready while o_rsp_valid=0 → ignored.

Test Plan:
Bench uses CLOCK_FREQ=1600, BAUD_RATE=100 (CLKS_PER_BIT=16) and TIMEOUT_CYCLES=1000.
- Write, addr=32'h0000_0010, data=32'hDEAD_BEEF → o_uart_tx decodes to AA 00 00 00 10 DE AD BE EF. o_rsp_valid rises 1440 cycles after the start bit, with data=0 and err=0.
- Read, addr=32'h0000_0004; bench UART replies 12 34 56 78 after the read frame ends → frame 01 00 00 00 04. o_rsp_data=32'h1234_5678, err=0.
- Read with no reply → o_rsp_valid with err=1 and data=0, exactly 1000 cycles after the last stop bit. Next request is accepted afterwards.
- Read reply where the third byte has stop bit=0 → err=1, data=0. Stray bytes injected during SEND and IDLE are ignored.
- Hold i_rsp_ready=0 for 50 cycles after o_rsp_valid → valid, data and err stay stable; o_req_ready=0 throughout. o_req_ready=1 one cycle after the handshake.
- Assert rst during the fourth byte of a write → next cycle o_uart_tx=1 and all outputs are at their reset values. A new read issued after reset produces a correct frame.

Source files
------------

// File: rtl/uart_wb_host_if.sv
// Request/response bundle between a loader client and the UART host endpoint.
// Signal names carry the endpoint's point of view (i_ = into the host, o_ = out of it).
interface uart_wb_host_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_data;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic                  o_rsp_err;

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_data, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_data, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );
endinterface

// File: rtl/uart_wb_host.sv
// Host endpoint of the UART memory-access protocol: serialises read/write command
// frames (8N1) and collects the 4-byte read reply with a per-byte timeout.
module uart_wb_host #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          BAUD_RATE      = 9600,
  parameter int          CLOCK_FREQ     = 50000000,
  parameter logic [7:0]  CMD_READ       = 8'h01,
  parameter logic [7:0]  CMD_WRITE      = 8'hAA,
  parameter int          TIMEOUT_CYCLES = 2000000
) (
  input  logic           clk,
  input  logic           rst,
  uart_wb_host_if.slave  bus,
  output logic           o_uart_tx,
  input  logic           i_uart_rx
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = 8 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    WR_LAST   = 4'd8;
  localparam logic [3:0]    RD_LAST   = 4'd4;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, RESP} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [3:0]            byte_idx_q, byte_idx_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic                  tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [1:0]            reply_cnt_q, reply_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [7:0]            cur_byte;

  logic                  rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t             rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_clk_q, rx_clk_d;
  logic [2:0]            rx_bit_q, rx_bit_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_ok_q, rx_ok_d;

  assign cur_byte        = frame_q[FW-1 -: 8];
  assign o_uart_tx       = tx_q;
  assign bus.o_req_ready = ready_q;
  assign bus.o_rsp_valid = (state_q == RESP);
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    frame_d     = frame_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    tx_cnt_d    = tx_cnt_q;
    tx_d        = tx_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    reply_cnt_d = reply_cnt_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid && ready_q) begin
          we_d       = bus.i_req_we;
          frame_d    = {bus.i_req_we ? CMD_WRITE : CMD_READ, bus.i_req_addr, bus.i_req_data};
          byte_idx_d = 4'd0;
          bit_idx_d  = 4'd0;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // bit_idx: 0 = start, 1..8 = data LSB-first, 9 = stop
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (bit_idx_q == 4'd9) begin
            if (byte_idx_q == (we_q ? WR_LAST : RD_LAST)) begin
              tx_d       = 1'b1;
              rsp_data_d = '0;
              rsp_err_d  = 1'b0;
              if (we_q) begin
                state_d = RESP;
              end else begin
                state_d     = WAIT_RX;
                reply_cnt_d = 2'd0;
                to_cnt_d    = '0;
              end
            end else begin
              byte_idx_d = byte_idx_q + 4'd1;
              bit_idx_d  = 4'd0;
              frame_d    = frame_q << 8;
              tx_d       = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      WAIT_RX: begin
        // A completed byte takes priority over a simultaneous timeout.
        if (rx_valid_q) begin
          if (rx_ok_q) begin
            rsp_data_d  = {rsp_data_q[DATA_WIDTH-9:0], rx_shift_q};
            to_cnt_d    = '0;
            reply_cnt_d = reply_cnt_q + 2'd1;
            if (reply_cnt_q == 2'd3) state_d = RESP;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_clk_d   = rx_clk_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ok_d    = rx_ok_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_clk_d   = '0;
        end
      end
      RX_START: begin
        if (rx_clk_q == HALF_LAST) begin
          rx_clk_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_clk_d = rx_clk_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_clk_q == BIT_LAST) begin
          rx_clk_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_clk_d = rx_clk_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_clk_q == BIT_LAST) begin
          rx_valid_d = 1'b1;
          rx_ok_d    = rx_s2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_clk_d = rx_clk_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      frame_q     <= '0;
      byte_idx_q  <= 4'd0;
      bit_idx_q   <= 4'd0;
      tx_cnt_q    <= '0;
      tx_q        <= 1'b1;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      reply_cnt_q <= 2'd0;
      to_cnt_q    <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_clk_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      frame_q     <= frame_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_q        <= tx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      reply_cnt_q <= reply_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rx_s1_q     <= i_uart_rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_clk_q    <= rx_clk_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_ok_q     <= rx_ok_d;
    end
  end
endmodule

// File: tb/tb_uart_wb_host.sv
// Scoreboard bench for uart_wb_host: expected TX bytes and responses are queued
// when requests are issued and checked as the DUT produces them.
module tb_uart_wb_host;
  localparam int CF  = 1600;
  localparam int BR  = 100;
  localparam int TO  = 1000;
  localparam int CPB = CF / BR;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          rise;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
  logic uart_rx = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  logic [7:0] exp_tx_q[$];
  rsp_t       exp_rsp[$];

  uart_wb_host_if bus ();

  uart_wb_host #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BAUD_RATE(BR), .CLOCK_FREQ(CF),
    .CMD_READ(8'h01), .CMD_WRITE(8'hAA), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .o_uart_tx(uart_tx), .i_uart_rx(uart_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  // TX line monitor: decodes 8N1 bytes sampled mid-bit and checks them against exp_tx_q.
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'd0;
  logic       mon_start_ok = 1'b0;
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_start_ok = (uart_tx === 1'b0);
      end else if (mon_cnt > 8 && mon_cnt < 152 && ((mon_cnt - 8) % 16) == 0) begin
        mon_byte = {uart_tx, mon_byte[7:1]};
      end else if (mon_cnt == 152) begin
        mon_active = 1'b0;
        n_checks++;
        if (exp_tx_q.size() == 0) begin
          n_fails++;
          $display("FAIL tx_byte: got unexpected byte %02h, required none", mon_byte);
        end else begin
          mon_exp = exp_tx_q.pop_front();
          if (mon_byte !== mon_exp || !mon_start_ok || uart_tx !== 1'b1) begin
            n_fails++;
            $display("FAIL tx_byte: got %02h start_ok=%0b stop=%0b, required %02h start_ok=1 stop=1",
                     mon_byte, mon_start_ok, uart_tx, mon_exp);
          end else begin
            $display("tx byte %02h at cycle %0d", mon_byte, cyc);
          end
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input int rise_off, input logic [31:0] rdata, input logic rerr,
                        output int hs_cyc);
    logic [71:0] frame;
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_req_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 5000) begin
      n_fails++;
      $display("FAIL req_ready_wait: got ready=%0b after %0d cycles, required 1", bus.o_req_ready, n);
    end
    bus.i_req_we    = we;
    bus.i_req_addr  = addr;
    bus.i_req_data  = data;
    bus.i_req_valid = 1'b1;
    frame = {we ? 8'hAA : 8'h01, addr, data};
    for (int i = 0; i < (we ? 9 : 5); i++) exp_tx_q.push_back(frame[71 - 8 * i -: 8]);
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    hs_cyc = cyc;
    exp_rsp.push_back('{rdata, rerr, (rise_off < 0) ? -1 : hs_cyc + rise_off});
    $display("request we=%0b addr=%08h data=%08h accepted at cycle %0d", we, addr, data, hs_cyc);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    for (int i = 0; i < 9; i++) begin
      repeat (CPB) @(posedge clk);
      #1;
      uart_rx = (i < 8) ? b[i] : stop;
    end
    repeat (CPB) @(posedge clk);
    #1;
    uart_rx = 1'b1;
  endtask

  task automatic wait_frame_end(input int hs_cyc, input int len);
    while (cyc < hs_cyc + len * 10 * CPB) @(posedge clk);
  endtask

  task automatic wait_rsp(input int hold);
    rsp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_rsp_valid !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 5000 || exp_rsp.size() == 0) begin
      n_fails++;
      $display("FAIL rsp_wait: got valid=%0b pending=%0d, required a response", bus.o_rsp_valid, exp_rsp.size());
      return;
    end
    e = exp_rsp.pop_front();
    if (e.rise >= 0) begin
      n_checks++;
      if (cyc !== e.rise) begin
        n_fails++;
        $display("FAIL rsp_timing: valid rose at cycle %0d, required %0d", cyc, e.rise);
      end
    end
    n_checks++;
    if (exp_tx_q.size() != 0) begin
      n_fails++;
      $display("FAIL tx_frame: got %0d bytes unsent at response, required 0", exp_tx_q.size());
    end
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== e.data || bus.o_rsp_err !== e.err
          || bus.o_req_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL rsp_value[%0d]: got valid=%0b data=%08h err=%0b ready=%0b, required 1 %08h %0b 0",
                 k, bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err, bus.o_req_ready, e.data, e.err);
      end
    end
    $display("response data=%08h err=%0b at cycle %0d", bus.o_rsp_data, bus.o_rsp_err, cyc);
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL post_handshake: got ready=%0b valid=%0b, required 1 0", bus.o_req_ready, bus.o_rsp_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (uart_tx !== 1'b1 || bus.o_req_ready !== 1'b0 || bus.o_rsp_valid !== 1'b0
        || bus.o_rsp_data !== 32'h0 || bus.o_rsp_err !== 1'b0) begin
      n_fails++;
      $display("FAIL %s: got tx=%0b ready=%0b valid=%0b data=%08h err=%0b, required 1 0 0 00000000 0",
               tag, uart_tx, bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.o_req_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL ready_after_reset: got %0b, required 1", bus.o_req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    release_reset();
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_write();
    int hs;
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1440, 32'h0, 1'b0, hs);
    wait_rsp(0);
  endtask

  task automatic test_read();
    int hs;
    logic [31:0] r;
    r = 32'h1234_5678;
    do_req(1'b0, 32'h0000_0004, 32'h0, -1, r, 1'b0, hs);
    wait_frame_end(hs, 5);
    for (int i = 3; i >= 0; i--) send_rx(r[8 * i +: 8], 1'b1);
    wait_rsp(0);
  endtask

  task automatic test_timeout();
    int hs;
    do_req(1'b0, 32'h0000_0100, 32'h0, 5 * 10 * CPB + TO, 32'h0, 1'b1, hs);
    wait_rsp(0);
  endtask

  task automatic test_stop_err();
    int hs;
    send_rx(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_err !== 1'b0 || bus.o_req_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL idle_stray: got valid=%0b err=%0b ready=%0b, required 0 0 1",
               bus.o_rsp_valid, bus.o_rsp_err, bus.o_req_ready);
    end
    do_req(1'b0, 32'h0000_0008, 32'h0, -1, 32'h0, 1'b1, hs);
    send_rx(8'hC3, 1'b1);
    wait_frame_end(hs, 5);
    send_rx(8'h12, 1'b1);
    send_rx(8'h34, 1'b1);
    send_rx(8'h56, 1'b0);
    wait_rsp(0);
  endtask

  task automatic test_hold();
    int hs;
    do_req(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1440, 32'h0, 1'b0, hs);
    wait_rsp(50);
  endtask

  task automatic test_reset_mid();
    int hs;
    logic [31:0] r;
    r = 32'hA55A_0FF0;
    do_req(1'b1, 32'h0000_0030, 32'h1122_3344, -1, 32'h0, 1'b0, hs);
    while (cyc < hs + 3 * 10 * CPB + 50) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_tx_q.delete();
    exp_rsp.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid_frame");
    release_reset();
    do_req(1'b0, 32'hCAFE_0100, 32'h0, -1, r, 1'b0, hs);
    wait_frame_end(hs, 5);
    for (int i = 3; i >= 0; i--) send_rx(r[8 * i +: 8], 1'b1);
    wait_rsp(0);
  endtask

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_we    = 1'b0;
    bus.i_req_addr  = 32'h0;
    bus.i_req_data  = 32'h0;
    bus.i_rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_stop_err();
    test_hold();
    test_reset_mid();
    n_checks++;
    if (exp_tx_q.size() != 0 || exp_rsp.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d tx and %0d rsp pending, required 0 0",
               exp_tx_q.size(), exp_rsp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
